// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph table, FSM states and glyph helper.
// Used by the reader today and by the display encoder later.
package seg7_pkg;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  typedef enum logic [1:0] {
    SETTLE,
    ACCEPT,
    LOCKED
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] digit;
  } glyph_t;

  // Illegal patterns return legal=0 with digit 0.
  function automatic glyph_t glyph_to_nibble(
    input logic [6:0] seg
  );
    glyph_t g;
    g.legal = 1'b1;
    g.digit = 4'h0;
    case (seg)
      GLYPH_0: g.digit = 4'h0;
      GLYPH_1: g.digit = 4'h1;
      GLYPH_2: g.digit = 4'h2;
      GLYPH_3: g.digit = 4'h3;
      GLYPH_4: g.digit = 4'h4;
      GLYPH_5: g.digit = 4'h5;
      GLYPH_6: g.digit = 4'h6;
      GLYPH_7: g.digit = 4'h7;
      GLYPH_8: g.digit = 4'h8;
      GLYPH_9: g.digit = 4'h9;
      GLYPH_A: g.digit = 4'hA;
      GLYPH_B: g.digit = 4'hB;
      GLYPH_C: g.digit = 4'hC;
      GLYPH_D: g.digit = 4'hD;
      GLYPH_E: g.digit = 4'hE;
      GLYPH_F: g.digit = 4'hF;
      default: g.legal = 1'b0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph decoder: segment pattern to
// legal/blank flags and hex nibble.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic       is_blank,
  output logic [3:0] digit
);

  glyph_t g;

  always_comb begin
    g        = glyph_to_nibble(seg);
    legal    = g.legal;
    digit    = g.digit;
    is_blank = (seg == GLYPH_BLANK);
  end

endmodule

// File: rtl/seg7_reader.sv
// Debounced 7-segment reader with valid/ready output.
// Sequence checker built only with SEG7_READER_SEQ_CHECK_EN.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [3:0]       digit_out,
  output logic             blank,
  output logic             pattern_err,
  output logic             overrun,
  output logic             seq_ok,
  output logic [CNT_W-1:0] seq_err_count
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  logic [6:0] seg_q;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       mismatch;
  state_t     state_q;
  state_t     state_d;
  logic       accept;

  logic       legal;
  logic       is_blank;
  logic [3:0] digit;

  seg7_glyph_decode u_decode (
    .seg      (seg_q),
    .legal    (legal),
    .is_blank (is_blank),
    .digit    (digit)
  );

  assign mismatch = (seg_in != seg_q);

  always_comb begin
    cnt_d = cnt_q;
    if (mismatch)
      cnt_d = 4'd1;
    else if (cnt_q < STABLE)
      cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= '0;
      cnt_q <= '0;
    end else begin
      seg_q <= seg_in;
      cnt_q <= cnt_d;
    end
  end

  // ACCEPT always completes, even if the bus moves on that edge.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      SETTLE: begin
        if (!mismatch && cnt_d == STABLE)
          state_d = ACCEPT;
      end
      ACCEPT: begin
        accept  = 1'b1;
        state_d = mismatch ? SETTLE : LOCKED;
      end
      LOCKED: begin
        if (mismatch)
          state_d = SETTLE;
      end
      default: state_d = SETTLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= SETTLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      digit_out   <= '0;
      blank       <= 1'b0;
      pattern_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      pattern_err <= accept && !legal && !is_blank;
      if (accept && legal) begin
        digit_out <= digit;
        out_valid <= 1'b1;
        if (out_valid && !out_ready)
          overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && is_blank)
        blank <= 1'b1;
      else if (mismatch)
        blank <= 1'b0;
    end
  end

`ifdef SEG7_READER_SEQ_CHECK_EN
  logic             have_ref;
  logic [3:0]       prev_q;
  logic [3:0]       prev_inc;
  logic [CNT_W-1:0] err_q;
  logic             ok_q;

  assign prev_inc = prev_q + 4'd1;

  // A blank drops the reference so the next digit starts fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      have_ref <= 1'b0;
      prev_q   <= '0;
      err_q    <= '0;
      ok_q     <= 1'b0;
    end else if (accept) begin
      if (legal) begin
        prev_q   <= digit;
        have_ref <= 1'b1;
        if (!have_ref) begin
          ok_q <= 1'b0;
        end else if (digit == prev_inc) begin
          ok_q <= 1'b1;
        end else begin
          ok_q <= 1'b0;
          if (err_q != '1)
            err_q <= err_q + 1'b1;
        end
      end else if (is_blank) begin
        have_ref <= 1'b0;
      end
    end
  end

  assign seq_ok        = ok_q;
  assign seq_err_count = err_q;
`else
  assign seq_ok        = 1'b0;
  assign seq_err_count = '0;
`endif

endmodule

// File: tb/tb_seg7_reader.sv
// Scoreboard bench for seg7_reader: directed glyph vectors,
// monitor pops expected digits on each handshake.
module tb_seg7_reader;

`ifdef SEG7_READER_SEQ_CHECK_EN
  localparam bit SEQ = 1'b1;
`else
  localparam bit SEQ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_in;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] digit_out;
  logic       blank;
  logic       pattern_err;
  logic       overrun;
  logic       seq_ok;
  logic [7:0] seq_err_count;

  seg7_reader #(
    .STABLE_CYCLES (4),
    .CNT_W         (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .seg_in        (seg_in),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .digit_out     (digit_out),
    .blank         (blank),
    .pattern_err   (pattern_err),
    .overrun       (overrun),
    .seq_ok        (seq_ok),
    .seq_err_count (seq_err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic       sok;
    logic       chk_sok;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int err_pulses = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] d,
                      input logic sok,
                      input logic chk_sok,
                      input logic [7:0] cnt);
    exp_t e;
    e.d       = d;
    e.sok     = sok & SEQ;
    e.chk_sok = chk_sok;
    e.cnt     = SEQ ? cnt : 8'd0;
    q.push_back(e);
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    seg_in = p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (pattern_err)
      err_pulses++;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_digit", {28'd0, digit_out}, 32'hFFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("digit", {28'd0, digit_out}, {28'd0, e.d});
        if (e.chk_sok)
          chk("seq_ok", {31'd0, seq_ok}, {31'd0, e.sok});
        chk("seq_cnt", {24'd0, seq_err_count}, {24'd0, e.cnt});
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 0);
    chk({tag, "_digit"}, {28'd0, digit_out}, 0);
    chk({tag, "_blank"}, {31'd0, blank}, 0);
    chk({tag, "_perr"}, {31'd0, pattern_err}, 0);
    chk({tag, "_ovr"}, {31'd0, overrun}, 0);
    chk({tag, "_sok"}, {31'd0, seq_ok}, 0);
    chk({tag, "_scnt"}, {24'd0, seq_err_count}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running want=done");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    rst       = 1'b1;
    seg_in    = 7'h3F;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");

    // digit 0 after capture + 4 edges, consumed next edge
    @(posedge clk);
    #1 rst = 1'b0;
    push(4'h0, 1'b0, 1'b1, 8'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("lat_early_valid", {31'd0, out_valid}, 0);
    @(negedge clk);
    chk("lat_valid", {31'd0, out_valid}, 1);
    chk("lat_digit", {28'd0, digit_out}, 0);
    @(negedge clk);
    chk("consumed", {31'd0, out_valid}, 0);
    @(posedge clk);
    #1;

    // counting run 1,2,3,F,0
    push(4'h1, 1'b1, 1'b1, 8'd0);
    push(4'h2, 1'b1, 1'b1, 8'd0);
    push(4'h3, 1'b1, 1'b1, 8'd0);
    push(4'hF, 1'b0, 1'b1, 8'd1);
    push(4'h0, 1'b1, 1'b1, 8'd1);
    hold(7'h06, 4);
    hold(7'h5B, 4);
    hold(7'h4F, 4);
    hold(7'h71, 4);
    hold(7'h3F, 6);
    chk("run_seq_cnt", {24'd0, seq_err_count},
        SEQ ? 32'd1 : 32'd0);
    chk("run_q_empty", q.size(), 0);

    // short glitch to 1 then back to 0
    push(4'h0, 1'b0, 1'b1, 8'd2);
    hold(7'h3F, 3);
    hold(7'h06, 1);
    hold(7'h3F, 6);
    chk("glitch_q_empty", q.size(), 0);

    // illegal pattern
    p0 = err_pulses;
    hold(7'h55, 10);
    chk("illegal_pulses", err_pulses - p0, 1);
    chk("illegal_valid", {31'd0, out_valid}, 0);
    chk("illegal_digit", {28'd0, digit_out}, 0);

    // blank between 5 and 7, then 8
    push(4'h5, 1'b0, 1'b1, 8'd3);
    hold(7'h6D, 6);
    hold(7'h00, 6);
    chk("blank_set", {31'd0, blank}, 1);
    chk("blank_valid", {31'd0, out_valid}, 0);
    push(4'h7, 1'b0, 1'b0, 8'd3);
    hold(7'h07, 6);
    chk("blank_clr", {31'd0, blank}, 0);
    push(4'h8, 1'b1, 1'b1, 8'd3);
    hold(7'h7F, 6);
    chk("blank_q_empty", q.size(), 0);

    // overrun with consumer stalled
    out_ready = 1'b0;
    hold(7'h06, 6);
    chk("ovr_first", {31'd0, overrun}, 0);
    hold(7'h5B, 6);
    chk("ovr_digit", {28'd0, digit_out}, 2);
    chk("ovr_valid", {31'd0, out_valid}, 1);
    chk("ovr_set", {31'd0, overrun}, 1);
    hold(7'h5B, 3);
    chk("ovr_sticky", {31'd0, overrun}, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");

    // fresh accept after reset
    push(4'h2, 1'b0, 1'b1, 8'd0);
    hold(7'h5B, 8);
    chk("final_q_empty", q.size(), 0);
    chk("total_err_pulses", err_pulses, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
